// File: rtl/mul_div_unit.sv
// Iterative 32-bit multiply/divide unit with HI/LO registers.
// One shift-add or restoring-divide step per clock; 33 busy cycles per operation.
module mul_div_unit (
  input  logic        CLK,
  input  logic        RST,
  input  logic        Start,
  input  logic [1:0]  MdOp,
  input  logic [31:0] DataIn1,
  input  logic [31:0] DataIn2,
  input  logic        HiWrite,
  input  logic        LoWrite,
  output logic        Busy,
  output logic        Done,
  output logic [31:0] Hi,
  output logic [31:0] Lo
);

  typedef enum logic [1:0] {StIdle, StRun, StFinish} stateT;

  stateT       stateQ, stateD;
  logic [4:0]  cntQ, cntD;
  logic [1:0]  opQ, opD;
  logic        signAQ, signAD, signBQ, signBD;
  logic [31:0] opBQ, opBD;
  logic [63:0] accQ, accD;
  logic [31:0] hiQ, hiD, loQ, loD;
  logic        doneQ, doneD;

  logic        isSigned;
  logic [31:0] magA, magB;
  logic [32:0] mulSum, remShift, divDiff;
  logic [63:0] negAcc;
  logic [31:0] quo, rem;

  always_comb begin
    stateD = stateQ;
    cntD   = cntQ;
    opD    = opQ;
    signAD = signAQ;
    signBD = signBQ;
    opBD   = opBQ;
    accD   = accQ;
    hiD    = hiQ;
    loD    = loQ;
    doneD  = 1'b0;

    isSigned = ~MdOp[0];
    magA     = (isSigned && DataIn1[31]) ? (~DataIn1 + 32'd1) : DataIn1;
    magB     = (isSigned && DataIn2[31]) ? (~DataIn2 + 32'd1) : DataIn2;

    // Multiply: add multiplicand into the upper half when the low bit is set, then shift right.
    mulSum   = {1'b0, accQ[63:32]} + (accQ[0] ? {1'b0, opBQ} : 33'd0);
    // Divide: {remainder, quotient} shifts left; restore when the trial subtraction underflows.
    remShift = {accQ[63:32], accQ[31]};
    divDiff  = remShift - {1'b0, opBQ};

    negAcc = ~accQ + 64'd1;
    quo    = accQ[31:0];
    rem    = accQ[63:32];

    unique case (stateQ)
      StIdle: begin
        if (Start) begin
          opD    = MdOp;
          signAD = isSigned & DataIn1[31];
          signBD = isSigned & DataIn2[31];
          accD   = {32'd0, magA};
          opBD   = magB;
          cntD   = 5'd0;
          stateD = StRun;
        end else begin
          if (HiWrite) hiD = DataIn1;
          if (LoWrite) loD = DataIn1;
        end
      end
      StRun: begin
        if (opQ[1]) begin
          accD = divDiff[32] ? {remShift[31:0], accQ[30:0], 1'b0}
                             : {divDiff[31:0], accQ[30:0], 1'b1};
        end else begin
          accD = {mulSum, accQ[31:1]};
        end
        cntD = cntQ + 5'd1;
        if (cntQ == 5'd31) stateD = StFinish;
      end
      StFinish: begin
        if (!opQ[1]) begin
          {hiD, loD} = (!opQ[0] && (signAQ ^ signBQ)) ? negAcc : accQ;
        end else begin
          loD = (!opQ[0] && (signAQ ^ signBQ)) ? (~quo + 32'd1) : quo;
          hiD = (!opQ[0] && signAQ) ? (~rem + 32'd1) : rem;
          // Division by zero: quotient is all ones regardless of signs; remainder is the dividend.
          if (opBQ == 32'd0) loD = 32'hFFFF_FFFF;
        end
        doneD  = 1'b1;
        stateD = StIdle;
      end
      default: stateD = StIdle;
    endcase
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      stateQ <= StIdle;
      cntQ   <= 5'd0;
      opQ    <= 2'd0;
      signAQ <= 1'b0;
      signBQ <= 1'b0;
      opBQ   <= 32'd0;
      accQ   <= 64'd0;
      hiQ    <= 32'd0;
      loQ    <= 32'd0;
      doneQ  <= 1'b0;
    end else begin
      stateQ <= stateD;
      cntQ   <= cntD;
      opQ    <= opD;
      signAQ <= signAD;
      signBQ <= signBD;
      opBQ   <= opBD;
      accQ   <= accD;
      hiQ    <= hiD;
      loQ    <= loD;
      doneQ  <= doneD;
    end
  end

  assign Busy = (stateQ != StIdle);
  assign Done = doneQ;
  assign Hi   = hiQ;
  assign Lo   = loQ;

endmodule

// File: tb/tb_mul_div_unit.sv
// Directed-vector bench for mul_div_unit: latency, arithmetic corner cases and control priority.
module tb_mul_div_unit;

  logic        CLK, RST, Start, HiWrite, LoWrite;
  logic [1:0]  MdOp;
  logic [31:0] DataIn1, DataIn2;
  logic        Busy, Done;
  logic [31:0] Hi, Lo;

  int checks = 0;
  int errors = 0;

  localparam logic [1:0] OpMult = 2'b00, OpMultu = 2'b01, OpDiv = 2'b10, OpDivu = 2'b11;

  mul_div_unit dut (
    .CLK(CLK), .RST(RST), .Start(Start), .MdOp(MdOp), .DataIn1(DataIn1), .DataIn2(DataIn2),
    .HiWrite(HiWrite), .LoWrite(LoWrite), .Busy(Busy), .Done(Done), .Hi(Hi), .Lo(Lo)
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  // Starts one operation, scrambles the inputs after the accept edge and waits for completion.
  task automatic run_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                        output int busyCycles, output int doneWhileBusy,
                        output logic doneEnd, output logic doneAfter);
    @(negedge CLK);
    Start = 1'b1; MdOp = op; DataIn1 = a; DataIn2 = b;
    @(posedge CLK);
    #1;
    Start = 1'b0; MdOp = ~op; DataIn1 = ~a; DataIn2 = ~b;
    busyCycles = 0;
    doneWhileBusy = 0;
    @(negedge CLK);
    while (Busy && busyCycles < 100) begin
      busyCycles++;
      if (Done) doneWhileBusy++;
      @(negedge CLK);
    end
    doneEnd = Done;
    @(negedge CLK);
    doneAfter = Done;
  endtask

  task automatic test_reset;
    #2;
    checks++; if (Busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", Busy); end
    checks++; if (Done !== 1'b0) begin errors++; $display("FAIL reset_done got %b want 0", Done); end
    checks++; if (Hi !== 32'h0) begin errors++; $display("FAIL reset_hi got %h want 0", Hi); end
    checks++; if (Lo !== 32'h0) begin errors++; $display("FAIL reset_lo got %h want 0", Lo); end
    @(negedge CLK);
    RST = 1'b1;
  endtask

  task automatic test_multu_max;
    int bc, db;
    logic de, da;
    run_op(OpMultu, 32'hFFFF_FFFF, 32'hFFFF_FFFF, bc, db, de, da);
    checks++; if (bc != 33) begin errors++; $display("FAIL multu_busy_cycles got %0d want 33", bc); end
    checks++; if (db != 0) begin errors++; $display("FAIL multu_done_early got %0d want 0", db); end
    checks++; if (de !== 1'b1) begin errors++; $display("FAIL multu_done got %b want 1", de); end
    checks++; if (da !== 1'b0) begin errors++; $display("FAIL multu_done_width got %b want 0", da); end
    checks++; if (Hi !== 32'hFFFF_FFFE) begin errors++; $display("FAIL multu_hi got %h want fffffffe", Hi); end
    checks++; if (Lo !== 32'h0000_0001) begin errors++; $display("FAIL multu_lo got %h want 00000001", Lo); end
  endtask

  task automatic test_signed_arith;
    int bc, db;
    logic de, da;
    run_op(OpMult, 32'hFFFF_FFFD, 32'd7, bc, db, de, da);
    checks++; if (Hi !== 32'hFFFF_FFFF) begin errors++; $display("FAIL mult_hi got %h want ffffffff", Hi); end
    checks++; if (Lo !== 32'hFFFF_FFEB) begin errors++; $display("FAIL mult_lo got %h want ffffffeb", Lo); end
    run_op(OpDiv, 32'hFFFF_FFF9, 32'd2, bc, db, de, da);
    checks++; if (Lo !== 32'hFFFF_FFFD) begin errors++; $display("FAIL div_lo got %h want fffffffd", Lo); end
    checks++; if (Hi !== 32'hFFFF_FFFF) begin errors++; $display("FAIL div_hi got %h want ffffffff", Hi); end
    checks++; if (bc != 33) begin errors++; $display("FAIL div_busy_cycles got %0d want 33", bc); end
    run_op(OpDivu, 32'd1000, 32'd7, bc, db, de, da);
    checks++; if (Lo !== 32'd142) begin errors++; $display("FAIL divu_lo got %0d want 142", Lo); end
    checks++; if (Hi !== 32'd6) begin errors++; $display("FAIL divu_hi got %0d want 6", Hi); end
    run_op(OpMult, 32'h8000_0000, 32'h8000_0000, bc, db, de, da);
    checks++; if (Hi !== 32'h4000_0000) begin errors++; $display("FAIL mult_minsq_hi got %h want 40000000", Hi); end
    checks++; if (Lo !== 32'h0) begin errors++; $display("FAIL mult_minsq_lo got %h want 0", Lo); end
  endtask

  task automatic test_div_corner;
    int bc, db;
    logic de, da;
    run_op(OpDivu, 32'd100, 32'd0, bc, db, de, da);
    checks++; if (bc != 33) begin errors++; $display("FAIL divz_busy_cycles got %0d want 33", bc); end
    checks++; if (de !== 1'b1) begin errors++; $display("FAIL divz_done got %b want 1", de); end
    checks++; if (Lo !== 32'hFFFF_FFFF) begin errors++; $display("FAIL divuz_lo got %h want ffffffff", Lo); end
    checks++; if (Hi !== 32'h64) begin errors++; $display("FAIL divuz_hi got %h want 00000064", Hi); end
    run_op(OpDiv, 32'hFFFF_FFFB, 32'd0, bc, db, de, da);
    checks++; if (Lo !== 32'hFFFF_FFFF) begin errors++; $display("FAIL divz_lo got %h want ffffffff", Lo); end
    checks++; if (Hi !== 32'hFFFF_FFFB) begin errors++; $display("FAIL divz_hi got %h want fffffffb", Hi); end
    run_op(OpDiv, 32'h8000_0000, 32'hFFFF_FFFF, bc, db, de, da);
    checks++; if (Lo !== 32'h8000_0000) begin errors++; $display("FAIL divovf_lo got %h want 80000000", Lo); end
    checks++; if (Hi !== 32'h0) begin errors++; $display("FAIL divovf_hi got %h want 0", Hi); end
  endtask

  task automatic test_mt_writes;
    int bc, db;
    logic de, da;
    @(negedge CLK);
    HiWrite = 1'b1; LoWrite = 1'b1; DataIn1 = 32'hA5A5_A5A5;
    @(negedge CLK);
    HiWrite = 1'b1; LoWrite = 1'b0; DataIn1 = 32'h11;
    checks++; if (Hi !== 32'hA5A5_A5A5) begin errors++; $display("FAIL mt_both_hi got %h want a5a5a5a5", Hi); end
    checks++; if (Lo !== 32'hA5A5_A5A5) begin errors++; $display("FAIL mt_both_lo got %h want a5a5a5a5", Lo); end
    @(negedge CLK);
    HiWrite = 1'b0; LoWrite = 1'b1; DataIn1 = 32'h22;
    @(negedge CLK);
    LoWrite = 1'b0;
    checks++; if (Hi !== 32'h11) begin errors++; $display("FAIL mthi_hi got %h want 11", Hi); end
    checks++; if (Lo !== 32'h22) begin errors++; $display("FAIL mtlo_lo got %h want 22", Lo); end
    // Start together with both writes: the writes are dropped.
    Start = 1'b1; MdOp = OpMultu; DataIn1 = 32'd3; DataIn2 = 32'd4; HiWrite = 1'b1; LoWrite = 1'b1;
    @(posedge CLK);
    #1;
    Start = 1'b0; HiWrite = 1'b0; LoWrite = 1'b0;
    checks++; if (Busy !== 1'b1) begin errors++; $display("FAIL prio_busy got %b want 1", Busy); end
    checks++; if (Hi !== 32'h11) begin errors++; $display("FAIL prio_hi got %h want 11", Hi); end
    checks++; if (Lo !== 32'h22) begin errors++; $display("FAIL prio_lo got %h want 22", Lo); end
    bc = 0;
    while (Busy && bc < 100) begin bc++; @(negedge CLK); end
    checks++; if (Lo !== 32'd12) begin errors++; $display("FAIL prio_result_lo got %0d want 12", Lo); end
    // Back-to-back operation straight after the previous one.
    run_op(OpMultu, 32'd9, 32'd9, bc, db, de, da);
    checks++; if (Lo !== 32'd81 || Hi !== 32'd0) begin
      errors++; $display("FAIL b2b_result got %h_%h want 00000000_00000051", Hi, Lo);
    end
  endtask

  task automatic test_combined;
    int bc, dn;
    @(negedge CLK);
    HiWrite = 1'b1; LoWrite = 1'b1; DataIn1 = 32'd0;
    @(negedge CLK);
    HiWrite = 1'b0; LoWrite = 1'b0;
    Start = 1'b1; MdOp = OpMultu; DataIn1 = 32'd5; DataIn2 = 32'd6;
    @(posedge CLK);
    #1;
    Start = 1'b0;
    repeat (10) @(posedge CLK);
    @(negedge CLK);
    Start = 1'b1; MdOp = OpDivu; DataIn1 = 32'd9; DataIn2 = 32'd3; HiWrite = 1'b1;
    @(posedge CLK);
    #1;
    Start = 1'b0; HiWrite = 1'b0;
    checks++; if (Hi !== 32'd0) begin errors++; $display("FAIL busy_mthi_hi got %h want 0", Hi); end
    bc = 0;
    dn = 0;
    @(negedge CLK);
    while (Busy && bc < 100) begin bc++; @(negedge CLK); end
    if (Done) dn = 1;
    checks++; if (bc != 22) begin errors++; $display("FAIL busy_start_cycles got %0d want 22", bc); end
    checks++; if (dn != 1) begin errors++; $display("FAIL busy_start_done got %0d want 1", dn); end
    checks++; if (Lo !== 32'd30) begin errors++; $display("FAIL busy_start_lo got %0d want 30", Lo); end
    checks++; if (Hi !== 32'd0) begin errors++; $display("FAIL busy_start_hi got %0d want 0", Hi); end

    // Second run, abandoned by reset at iteration 10.
    @(negedge CLK);
    Start = 1'b1; MdOp = OpMultu; DataIn1 = 32'd5; DataIn2 = 32'd6;
    @(posedge CLK);
    #1;
    Start = 1'b0;
    repeat (10) @(posedge CLK);
    #1;
    RST = 1'b0;
    #1;
    checks++; if (Busy !== 1'b0) begin errors++; $display("FAIL rst_run_busy got %b want 0", Busy); end
    checks++; if (Hi !== 32'd0) begin errors++; $display("FAIL rst_run_hi got %h want 0", Hi); end
    checks++; if (Lo !== 32'd0) begin errors++; $display("FAIL rst_run_lo got %h want 0", Lo); end
    dn = 0;
    repeat (2) begin @(negedge CLK); if (Done) dn++; end
    RST = 1'b1;
    repeat (40) begin @(negedge CLK); if (Done || Busy) dn++; end
    checks++; if (dn != 0) begin errors++; $display("FAIL rst_run_no_done got %0d want 0", dn); end
    checks++; if (Lo !== 32'd0) begin errors++; $display("FAIL rst_run_lo_held got %h want 0", Lo); end

    HiWrite = 1'b1; DataIn1 = 32'h1234;
    @(posedge CLK);
    #1;
    HiWrite = 1'b0;
    checks++; if (Hi !== 32'h1234) begin errors++; $display("FAIL mthi_after_rst got %h want 1234", Hi); end
    checks++; if (Lo !== 32'h0) begin errors++; $display("FAIL mthi_after_rst_lo got %h want 0", Lo); end
  endtask

  task automatic test_first_start;
    int bc;
    @(negedge CLK);
    RST = 1'b0;
    @(negedge CLK);
    RST = 1'b1;
    Start = 1'b1; MdOp = OpMultu; DataIn1 = 32'd7; DataIn2 = 32'd8;
    @(posedge CLK);
    #1;
    Start = 1'b0;
    checks++; if (Busy !== 1'b1) begin errors++; $display("FAIL first_start_busy got %b want 1", Busy); end
    bc = 0;
    @(negedge CLK);
    while (Busy && bc < 100) begin bc++; @(negedge CLK); end
    checks++; if (bc != 33) begin errors++; $display("FAIL first_start_cycles got %0d want 33", bc); end
    checks++; if (Lo !== 32'd56 || Hi !== 32'd0) begin
      errors++; $display("FAIL first_start_result got %h_%h want 00000000_00000038", Hi, Lo);
    end
  endtask

  initial begin
    RST = 1'b0; Start = 1'b0; MdOp = 2'b00; DataIn1 = 32'd0; DataIn2 = 32'd0;
    HiWrite = 1'b0; LoWrite = 1'b0;
    test_reset();
    test_multu_max();
    test_signed_arith();
    test_div_corner();
    test_mt_writes();
    test_combined();
    test_first_start();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
